// File: rtl/ext_ram_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for ext_ram_arbiter.
// Handshake: cpu_req is a level that is held until cpu_clken=1 while cpu_req=1 (completion); dma_req is held until the one-cycle dma_ack.
interface ext_ram_arbiter_if;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        cpu_clken;

    logic        dma_req;
    logic        dma_rnw;
    logic [18:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;

    logic        ram_cs_b;
    logic        ram_oe_b;
    logic        ram_we_b;
    logic [18:0] ram_addr;

    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_dout,
        output cpu_din, cpu_clken,
        input  dma_req, dma_rnw, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output ram_cs_b, ram_oe_b, ram_we_b, ram_addr
    );

    modport master (
        output cpu_req, cpu_rnw, cpu_addr, cpu_dout,
        input  cpu_din, cpu_clken,
        output dma_req, dma_rnw, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  ram_cs_b, ram_oe_b, ram_we_b, ram_addr
    );
endinterface

// File: rtl/ext_ram_arbiter.sv
// Shares an 8-bit SRAM between a CPU (16-bit words as two byte cycles) and a byte DMA port.
// Round-robin arbitration in IDLE; each byte phase lasts WAIT_STATES+1 cycles.
module ext_ram_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic             clock,
    input  logic             reset_b,
    ext_ram_arbiter_if.slave bus,
    inout  wire  [7:0]       ram_data,
    output logic [2:0]       o_dbg_state,
    output logic             o_dbg_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_LO   = 3'd1,
        S_CPU_HI   = 3'd2,
        S_CPU_DONE = 3'd3,
        S_DMA      = 3'd4,
        S_DMA_DONE = 3'd5
    } state_t;

    localparam logic [2:0] LAST_PHASE = 3'(WAIT_STATES);
    localparam logic       GRANT_CPU  = 1'b0;
    localparam logic       GRANT_DMA  = 1'b1;
    localparam logic       NO_HOLD    = (WAIT_STATES == 0);

    state_t      r_state, w_next_state;
    logic [2:0]  r_phase, w_next_phase;
    logic        r_last_grant, w_next_last_grant;
    logic [18:0] r_ram_addr, w_next_ram_addr;
    logic [15:0] r_cpu_din;
    logic [7:0]  r_dma_rdata;

    logic        w_active;
    logic        w_last_cycle;
    logic        w_rnw;
    logic        w_drive;
    logic [7:0]  w_wdata;

    always_comb begin
        w_active     = (r_state == S_CPU_LO) || (r_state == S_CPU_HI) || (r_state == S_DMA);
        w_last_cycle = (r_phase == LAST_PHASE);
        w_rnw        = (r_state == S_DMA) ? bus.dma_rnw : bus.cpu_rnw;
        w_drive      = w_active && !w_rnw;
        case (r_state)
            S_CPU_LO: w_wdata = bus.cpu_dout[7:0];
            S_CPU_HI: w_wdata = bus.cpu_dout[15:8];
            default:  w_wdata = bus.dma_wdata;
        endcase
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_phase      = r_phase;
        w_next_last_grant = r_last_grant;
        w_next_ram_addr   = r_ram_addr;
        case (r_state)
            S_IDLE: begin
                w_next_phase = 3'd0;
                // On a tie the requester that was not granted last time wins.
                if (bus.cpu_req && (!bus.dma_req || r_last_grant == GRANT_DMA)) begin
                    w_next_state      = S_CPU_LO;
                    w_next_last_grant = GRANT_CPU;
                    w_next_ram_addr   = {2'b00, bus.cpu_addr, 1'b0};
                end else if (bus.dma_req) begin
                    w_next_state      = S_DMA;
                    w_next_last_grant = GRANT_DMA;
                    w_next_ram_addr   = bus.dma_addr;
                end
            end
            S_CPU_LO: begin
                if (w_last_cycle) begin
                    w_next_state    = S_CPU_HI;
                    w_next_phase    = 3'd0;
                    w_next_ram_addr = {2'b00, bus.cpu_addr, 1'b1};
                end else begin
                    w_next_phase = r_phase + 3'd1;
                end
            end
            S_CPU_HI: begin
                if (w_last_cycle) begin
                    w_next_state = S_CPU_DONE;
                    w_next_phase = 3'd0;
                end else begin
                    w_next_phase = r_phase + 3'd1;
                end
            end
            S_DMA: begin
                if (w_last_cycle) begin
                    w_next_state = S_DMA_DONE;
                    w_next_phase = 3'd0;
                end else begin
                    w_next_phase = r_phase + 3'd1;
                end
            end
            S_CPU_DONE: w_next_state = S_IDLE;
            S_DMA_DONE: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= S_IDLE;
            r_phase      <= 3'd0;
            r_last_grant <= GRANT_DMA;
            r_ram_addr   <= 19'd0;
            r_cpu_din    <= 16'd0;
            r_dma_rdata  <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_phase      <= w_next_phase;
            r_last_grant <= w_next_last_grant;
            r_ram_addr   <= w_next_ram_addr;
            // Read data is captured on the final cycle of the phase, after the wait states.
            if (w_active && w_rnw && w_last_cycle) begin
                case (r_state)
                    S_CPU_LO: r_cpu_din[7:0]  <= ram_data;
                    S_CPU_HI: r_cpu_din[15:8] <= ram_data;
                    default:  r_dma_rdata     <= ram_data;
                endcase
            end
        end
    end

    // Strobes decode straight from the async-reset state, so they rise as soon as reset asserts.
    assign bus.ram_cs_b  = !w_active;
    assign bus.ram_oe_b  = !(w_active && w_rnw);
    assign bus.ram_we_b  = !(w_drive && (!w_last_cycle || NO_HOLD));
    assign bus.ram_addr  = r_ram_addr;
    assign ram_data      = w_drive ? w_wdata : 8'bz;

    assign bus.cpu_clken = !reset_b || !bus.cpu_req || (r_state == S_CPU_DONE);
    assign bus.cpu_din   = r_cpu_din;
    assign bus.dma_ack   = (r_state == S_DMA_DONE);
    assign bus.dma_rdata = r_dma_rdata;

    assign o_dbg_state   = r_state;
    assign o_dbg_data_oe = w_drive;

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// Bench for ext_ram_arbiter: directed cases plus random CPU/DMA traffic against a byte-array reference memory.
module tb_ext_ram_arbiter;
  localparam int W  = 1;
  localparam int WL = (W == 0) ? 1 : W;

  logic       clk;
  logic       reset_b;
  wire  [7:0] ram_data;
  logic [2:0] dbg_state;
  logic       dbg_data_oe;

  ext_ram_arbiter_if bus ();

  ext_ram_arbiter #(.WAIT_STATES(W)) dut (
    .clock         (clk),
    .reset_b       (reset_b),
    .bus           (bus),
    .ram_data      (ram_data),
    .o_dbg_state   (dbg_state),
    .o_dbg_data_oe (dbg_data_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with a backdoor preload port
  logic [7:0]  mem [0:(1<<19)-1];
  logic        pre_we;
  logic [18:0] pre_addr;
  logic [7:0]  pre_data;

  assign ram_data = (!bus.ram_cs_b && !bus.ram_oe_b) ? mem[bus.ram_addr] : 8'bz;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!bus.ram_cs_b && !bus.ram_we_b) mem[bus.ram_addr] <= ram_data;
  end

  // reference model and scoreboard
  logic [7:0] ref_mem [logic [18:0]];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // driver tasks
  task automatic preload(input logic [18:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #2;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Starts in an IDLE cycle and returns in the following IDLE cycle.
  task automatic cpu_access(input logic rnw, input logic [15:0] a, input logic [15:0] wd, input string tag);
    int c = 0;
    logic [31:0] oe_m = '0, we_m = '0, drv_m = '0;
    logic [18:0] lo_a = 19'(2 * int'(a));
    logic [18:0] seen_lo = '0, seen_hi = '0;
    logic data_ok = 1'b1;
    logic [7:0] exp_b;
    bus.cpu_rnw = rnw; bus.cpu_addr = a; bus.cpu_dout = wd; bus.cpu_req = 1'b1;
    #1;
    while (bus.cpu_clken !== 1'b1 && c < 40) begin
      if (bus.ram_oe_b === 1'b0) oe_m[c] = 1'b1;
      if (bus.ram_we_b === 1'b0) we_m[c] = 1'b1;
      if (dbg_data_oe === 1'b1) begin
        drv_m[c] = 1'b1;
        exp_b = (c <= W + 1) ? wd[7:0] : wd[15:8];
        if (ram_data !== exp_b) data_ok = 1'b0;
      end
      if (c == 1) seen_lo = bus.ram_addr;
      if (c == W + 2) seen_hi = bus.ram_addr;
      @(posedge clk); #2;
      c++;
    end
    check({tag, "_latency"}, c, 2 * W + 3);
    check({tag, "_addr_lo"}, seen_lo, lo_a);
    check({tag, "_addr_hi"}, seen_hi, lo_a + 19'd1);
    check({tag, "_oe_mask"}, oe_m, rnw ? range_mask(1, 2 * W + 2) : 32'd0);
    check({tag, "_drv_mask"}, drv_m, rnw ? 32'd0 : range_mask(1, 2 * W + 2));
    check({tag, "_we_mask"}, we_m, rnw ? 32'd0 : (range_mask(1, WL) | range_mask(W + 2, W + 1 + WL)));
    if (rnw) check({tag, "_rdata"}, bus.cpu_din, {ref_mem[lo_a + 19'd1], ref_mem[lo_a]});
    else begin
      check({tag, "_wdata_stable"}, data_ok, 1'b1);
      ref_mem[lo_a] = wd[7:0];
      ref_mem[lo_a + 19'd1] = wd[15:8];
    end
    bus.cpu_req = 1'b0;
    @(posedge clk); #2;
    check({tag, "_idle_strobes"}, {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b, dbg_data_oe}, 4'b1110);
  endtask

  task automatic dma_access(input logic rnw, input logic [18:0] a, input logic [7:0] wd, input string tag);
    int c = 0;
    logic [31:0] oe_m = '0, we_m = '0, drv_m = '0;
    logic data_ok = 1'b1;
    bus.dma_rnw = rnw; bus.dma_addr = a; bus.dma_wdata = wd; bus.dma_req = 1'b1;
    #1;
    while (bus.dma_ack !== 1'b1 && c < 40) begin
      if (bus.ram_oe_b === 1'b0) oe_m[c] = 1'b1;
      if (bus.ram_we_b === 1'b0) we_m[c] = 1'b1;
      if (dbg_data_oe === 1'b1) begin
        drv_m[c] = 1'b1;
        if (ram_data !== wd || bus.ram_addr !== a) data_ok = 1'b0;
      end
      @(posedge clk); #2;
      c++;
    end
    check({tag, "_ack_cycle"}, c, W + 2);
    check({tag, "_oe_mask"}, oe_m, rnw ? range_mask(1, W + 1) : 32'd0);
    check({tag, "_drv_mask"}, drv_m, rnw ? 32'd0 : range_mask(1, W + 1));
    check({tag, "_we_mask"}, we_m, rnw ? 32'd0 : range_mask(1, WL));
    if (rnw) check({tag, "_rdata"}, bus.dma_rdata, ref_mem[a]);
    else begin
      check({tag, "_wdata_stable"}, data_ok, 1'b1);
      ref_mem[a] = wd;
    end
    bus.dma_req = 1'b0;
    @(posedge clk); #2;
    check({tag, "_ack_pulse"}, bus.dma_ack, 1'b0);
  endtask

  byte         rr_ev [$];
  byte         rr_exp [4];
  logic [7:0]  last_dma_rd;

  initial begin
    rr_exp = '{"C", "D", "C", "D"};
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = '0; bus.cpu_dout = '0;
    bus.dma_req = 1'b0; bus.dma_rnw = 1'b1; bus.dma_addr = '0; bus.dma_wdata = '0;
    reset_b = 1'b0;
    #3;
    check("rst_strobes", {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b, dbg_data_oe}, 4'b1110);
    check("rst_clken", bus.cpu_clken, 1'b1);
    check("rst_cpu_din", bus.cpu_din, 16'h0000);
    check("rst_dma_rdata", bus.dma_rdata, 8'h00);
    check("rst_dma_ack", bus.dma_ack, 1'b0);
    check("rst_ram_addr", bus.ram_addr, 19'h0);
    bus.cpu_req = 1'b0;

    // preload the address pools while the arbiter sits in reset
    preload(19'h02468, 8'hCD);
    preload(19'h02469, 8'hAB);
    for (int i = 0; i < 16; i++) preload(19'h00200 + 19'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) preload(19'h7FFF0 + 19'(i), 8'($urandom));
    @(posedge clk); #2;
    reset_b = 1'b1;
    @(posedge clk); #2;

    // directed cases
    cpu_access(1'b1, 16'h1234, 16'h0000, "cpu_rd_1234");
    check("cpu_rd_1234_value", bus.cpu_din, 16'hABCD);
    cpu_access(1'b0, 16'h2000, 16'hBEEF, "cpu_wr_2000");
    check("sram_04000", mem[19'h04000], 8'hEF);
    check("sram_04001", mem[19'h04001], 8'hBE);
    cpu_access(1'b0, 16'hFFFF, 16'h5AA5, "cpu_wr_ffff");
    cpu_access(1'b1, 16'hFFFF, 16'h0000, "cpu_rd_ffff");
    dma_access(1'b0, 19'h7FFFF, 8'h5A, "dma_wr_7ffff");
    dma_access(1'b1, 19'h7FFFF, 8'h00, "dma_rd_7ffff");
    check("dma_rd_7ffff_value", bus.dma_rdata, 8'h5A);
    dma_access(1'b1, 19'h04001, 8'h00, "dma_rd_cpu_byte");

    // random mixed traffic over overlapping CPU/DMA byte ranges
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 3);
      case (kind)
        0: cpu_access(1'b1, 16'h0100 + 16'($urandom_range(0, 7)), 16'h0, "rnd_cpu_rd");
        1: cpu_access(1'b0, 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom), "rnd_cpu_wr");
        2: dma_access(1'b1, ($urandom_range(0, 1) != 0) ? 19'h00200 + 19'($urandom_range(0, 15))
                                                       : 19'h7FFF0 + 19'($urandom_range(0, 15)), 8'h0, "rnd_dma_rd");
        default: dma_access(1'b0, ($urandom_range(0, 1) != 0) ? 19'h00200 + 19'($urandom_range(0, 15))
                                                             : 19'h7FFF0 + 19'($urandom_range(0, 15)),
                            8'($urandom), "rnd_dma_wr");
      endcase
    end

    // both requesters held from reset: grants must alternate, CPU first
    reset_b = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 16'h0100;
    bus.dma_req = 1'b1; bus.dma_rnw = 1'b1; bus.dma_addr = 19'h00203;
    last_dma_rd = ref_mem[19'h00203];
    @(posedge clk); #2;
    reset_b = 1'b1;
    for (int k = 0; k < 120 && rr_ev.size() < 4; k++) begin
      @(posedge clk); #2;
      if (bus.dma_ack === 1'b1) rr_ev.push_back("D");
      else if (bus.cpu_clken === 1'b1) rr_ev.push_back("C");
    end
    check("rr_event_count", rr_ev.size(), 4);
    for (int i = 0; i < rr_ev.size(); i++) check("rr_order", rr_ev[i], rr_exp[i]);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    @(posedge clk); #2;
    check("rr_dma_rdata_held", bus.dma_rdata, last_dma_rd);

    // reset during the high-byte phase of a CPU write
    bus.cpu_rnw = 1'b0; bus.cpu_addr = 16'h3000; bus.cpu_dout = 16'h1111; bus.cpu_req = 1'b1;
    repeat (W + 2) @(posedge clk);
    #3;
    check("midrst_hi_we_active", bus.ram_we_b, 1'b0);
    reset_b = 1'b0;
    #1;
    check("midrst_strobes", {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b, dbg_data_oe}, 4'b1110);
    check("midrst_clken_forced", bus.cpu_clken, 1'b1);
    bus.cpu_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      check("midrst_no_ack", bus.dma_ack, 1'b0);
      check("midrst_strobes_held", {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b}, 3'b111);
    end
    reset_b = 1'b1;
    @(posedge clk); #2;
    cpu_access(1'b1, 16'h2000, 16'h0000, "post_rst_rd");
    check("post_rst_rd_value", bus.cpu_din, 16'hBEEF);

    // final sweep of every byte the reference model knows
    foreach (ref_mem[k]) check("sram_sweep", mem[k], ref_mem[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
